// File: rtl/reg_read_port_mux.sv
// ============================================================================
// Module   : reg_read_port_mux
// Purpose  : Registered multi-port register-file read mux with write bypass,
//            hardwired-zero register 0 and out-of-range address flagging.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_read_port_mux #(
  parameter int WORD_LENGTH = 32,
  parameter int SIZE        = 5,
  parameter int DEPTH       = 32,
  parameter int READ_PORTS  = 2,
  parameter int ZERO_REG    = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DEPTH*WORD_LENGTH-1:0]      data_flat,
  input  logic                              wr_en,
  input  logic [SIZE-1:0]                   wr_addr,
  input  logic [WORD_LENGTH-1:0]            wr_data,
  input  logic                              hold,
  input  logic [READ_PORTS-1:0]             rd_req,
  input  logic [READ_PORTS*SIZE-1:0]        rd_addr,
  output logic [READ_PORTS*WORD_LENGTH-1:0] rd_data,
  output logic [READ_PORTS-1:0]             rd_valid,
  output logic [READ_PORTS-1:0]             addr_err
);

  // One extra bit so DEPTH == 2**SIZE is representable for the range check.
  localparam logic [SIZE:0] c_depth = (SIZE+1)'(DEPTH);

  logic w_wr_fwd_ok;

  // A write is forwardable only if it targets real, writable storage.
  always_comb begin
    w_wr_fwd_ok = wr_en && ({1'b0, wr_addr} < c_depth);
    if ((ZERO_REG != 0) && (wr_addr == '0)) begin
      w_wr_fwd_ok = 1'b0;
    end
  end

  generate
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      logic [SIZE-1:0]        w_addr;
      logic                   w_oor;
      logic [WORD_LENGTH-1:0] w_sel;
      logic [WORD_LENGTH-1:0] data_d;
      logic [WORD_LENGTH-1:0] data_q;
      logic                   valid_d;
      logic                   valid_q;
      logic                   err_d;
      logic                   err_q;

      assign w_addr = rd_addr[p*SIZE +: SIZE];
      assign w_oor  = ({1'b0, w_addr} >= c_depth);

      always_comb begin
        w_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if (w_addr == i[SIZE-1:0]) begin
            w_sel = data_flat[i*WORD_LENGTH +: WORD_LENGTH];
          end
        end
      end

      always_comb begin
        data_d  = data_q;
        valid_d = rd_req[p];
        err_d   = 1'b0;
        if (rd_req[p]) begin
          if (w_oor) begin
            data_d = '0;
            err_d  = 1'b1;
          end else if ((ZERO_REG != 0) && (w_addr == '0)) begin
            data_d = '0;
          end else if (w_wr_fwd_ok && (wr_addr == w_addr)) begin
            data_d = wr_data;
          end else begin
            data_d = w_sel;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
        end else if (!hold) begin
          data_q  <= data_d;
          valid_q <= valid_d;
          err_q   <= err_d;
        end
      end

      assign rd_data[p*WORD_LENGTH +: WORD_LENGTH] = data_q;
      assign rd_valid[p]                           = valid_q;
      assign addr_err[p]                           = err_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_read_port_mux.sv
// ============================================================================
// Module   : tb_reg_read_port_mux
// Purpose  : Checks a 32-deep and a 24-deep instance against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_read_port_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        hold;
  logic [1:0]  rd_req;
  logic [4:0]  a0, a1;
  logic [9:0]  rd_addr;
  logic [31:0] regs [32];
  logic [32*32-1:0] flat_a;
  logic [24*32-1:0] flat_b;
  logic [63:0] data_a, data_b;
  logic [1:0]  valid_a, valid_b, err_a, err_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_data  [2][2];
  logic        m_valid [2][2];
  logic        m_err   [2][2];

  always #5 clk = ~clk;

  assign rd_addr = {a1, a0};

  always_comb begin
    for (int i = 0; i < 32; i++) flat_a[i*32 +: 32] = regs[i];
    for (int i = 0; i < 24; i++) flat_b[i*32 +: 32] = regs[i];
  end

  reg_read_port_mux #(.WORD_LENGTH(32), .SIZE(5), .DEPTH(32), .READ_PORTS(2), .ZERO_REG(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .data_flat(flat_a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .hold(hold), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(data_a), .rd_valid(valid_a), .addr_err(err_a));

  reg_read_port_mux #(.WORD_LENGTH(32), .SIZE(5), .DEPTH(24), .READ_PORTS(2), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .data_flat(flat_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .hold(hold), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(data_b), .rd_valid(valid_b), .addr_err(err_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural read result for one port of a register file of given depth.
  task automatic model_port(input int depth, input int addr, output logic [31:0] d, output logic e);
    e = 1'b0;
    if (addr >= depth) begin
      d = 32'h0;
      e = 1'b1;
    end else if (addr == 0) begin
      d = 32'h0;
    end else if (wr_en && int'(wr_addr) == addr) begin
      d = wr_data;
    end else begin
      d = regs[addr];
    end
  endtask

  task automatic tick();
    int depth [2];
    int addr [2];
    logic [31:0] d;
    logic e;
    depth[0] = 32; depth[1] = 24;
    addr[0] = int'(a0); addr[1] = int'(a1);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rst_n) begin
          m_data[k][p] = 32'h0; m_valid[k][p] = 1'b0; m_err[k][p] = 1'b0;
        end else if (!hold) begin
          m_valid[k][p] = rd_req[p];
          m_err[k][p]   = 1'b0;
          if (rd_req[p]) begin
            model_port(depth[k], addr[p], d, e);
            m_data[k][p] = d;
            m_err[k][p]  = e;
          end
        end
      end
    end
    if (rst_n && wr_en) regs[wr_addr] = wr_data;
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("a.data%0d", p),  data_a[p*32 +: 32], m_data[0][p]);
      chk($sformatf("a.valid%0d", p), {31'b0, valid_a[p]}, {31'b0, m_valid[0][p]});
      chk($sformatf("a.err%0d", p),   {31'b0, err_a[p]},   {31'b0, m_err[0][p]});
      chk($sformatf("b.data%0d", p),  data_b[p*32 +: 32], m_data[1][p]);
      chk($sformatf("b.valid%0d", p), {31'b0, valid_b[p]}, {31'b0, m_valid[1][p]});
      chk($sformatf("b.err%0d", p),   {31'b0, err_b[p]},   {31'b0, m_err[1][p]});
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;
    rst_n = 1'b0; hold = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    rd_req = 2'b11; a0 = 5'd4; a1 = 5'd9;

    // Reset with requests pending, then idle release.
    tick(); tick();
    chk("reset.data", data_a[31:0], 32'h0);
    chk("reset.valid", {30'b0, valid_a}, 32'h0);
    chk("reset.err", {30'b0, err_b}, 32'h0);
    rst_n = 1'b1; rd_req = 2'b00;
    tick();
    chk("idle.data", data_a[63:32], 32'h0);
    chk("idle.valid", {30'b0, valid_a}, 32'h0);

    // Plain read.
    rd_req = 2'b11; a0 = 5'd5; a1 = 5'd31;
    tick();
    chk("plain.p0", data_a[31:0], 32'hA000_0005);
    chk("plain.p1", data_a[63:32], 32'hA000_001F);
    chk("plain.valid", {30'b0, valid_a}, 32'h3);
    chk("plain.b_err1", {31'b0, err_b[1]}, 32'h1);

    // Bypass and zero register.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF; a0 = 5'd7; a1 = 5'd0;
    tick();
    chk("bypass.p0", data_a[31:0], 32'hDEAD_BEEF);
    chk("zero.p1", data_a[63:32], 32'h0);
    wr_addr = 5'd0; wr_data = 32'h1234_0000;
    tick();
    chk("b2b.p0", data_a[31:0], 32'hDEAD_BEEF);
    chk("zero_wr.p1", data_a[63:32], 32'h0);
    a1 = 5'd0; wr_en = 1'b0;
    tick();
    chk("zero_stored.p1", data_a[63:32], 32'h0);

    // Out-of-range on the 24-deep instance.
    rd_req = 2'b01; a0 = 5'd30;
    tick();
    chk("oor.data", data_b[31:0], 32'h0);
    chk("oor.err", {31'b0, err_b[0]}, 32'h1);
    rd_req = 2'b00;
    tick();
    chk("oor_clr.err", {31'b0, err_b[0]}, 32'h0);
    chk("oor_clr.data", data_b[31:0], 32'h0);

    // Hold freezes outputs, then releases to the pending request.
    regs[3] = 32'h1234_5678; rd_req = 2'b01; a0 = 5'd3;
    tick();
    chk("hold.pre", data_a[31:0], 32'h1234_5678);
    hold = 1'b1; a0 = 5'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold.data", data_a[31:0], 32'h1234_5678);
      chk("hold.valid", {31'b0, valid_a[0]}, 32'h1);
    end
    hold = 1'b0;
    tick();
    chk("hold.rel", data_a[31:0], 32'hA000_0009);

    // Reset mid-stream overrides hold.
    rd_req = 2'b11; a0 = 5'd12; a1 = 5'd13; hold = 1'b1; rst_n = 1'b0;
    tick();
    chk("midrst.data", data_a[63:32], 32'h0);
    chk("midrst.valid", {30'b0, valid_a}, 32'h0);
    rst_n = 1'b1; hold = 1'b0;
    tick();
    chk("resume.p1", data_a[63:32], 32'hA000_000D);

    // Randomized traffic with frequent write/read address collisions.
    for (int n = 0; n < 400; n++) begin
      rst_n   = ($urandom_range(0, 39) != 0);
      hold    = ($urandom_range(0, 7) == 0);
      rd_req  = 2'($urandom);
      a0      = 5'($urandom);
      a1      = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom);
      wr_en   = 1'($urandom);
      wr_addr = ($urandom_range(0, 1) == 0) ? a0 : 5'($urandom);
      wr_data = $urandom;
      if ($urandom_range(0, 15) == 0) regs[$urandom_range(0, 31)] = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
